adder_pipe: RTL and testbench

Multi-lane, parametrised successor to the combinational operand adder. LANES independent unsigned adders share one valid/ready handshake and feed an elastic pipeline STAGES deep. Each lane runs in one of two modes:
- Plain add: zero-extended A+B.
- Accumulate: saturating running sum.
Sits between operand producers and downstream datapath consumers that apply backpressure.

---
 rtl/adder_pipe.sv | 181 ++++++++++++++++++
 tb/tb_adder_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: multi-lane unsigned adder feeding an elastic register pipeline.
//
// Purpose
//   LANES independent adders share one valid/ready handshake. Each beat is
//   either a plain zero-extended add (mode=0) or a saturating accumulate into
//   a per-lane running sum (mode=1). Results travel through STAGES register
//   slots and leave through a second valid/ready handshake that tolerates
//   downstream backpressure.
//
// Handshake semantics (both sides)
//   A beat transfers on a rising edge where valid && ready. A producer holds
//   its valid and data stable until the transfer. in_ready depends only on
//   slot occupancy, out_ready and rst, never on in_valid.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset, discards all in-flight beats
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   A, B       packed operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mode       0 = plain add, 1 = accumulate (sampled with the beat)
//   clear      synchronous clear of all lane accumulators
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   X          packed results, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   sat        per-lane saturation flag of the current result beat
//   beat_count output handshake counter (only with ADDER_PIPE_COUNT_EN)
//
// Build option
//   `define ADDER_PIPE_COUNT_EN adds the 32-bit wrapping beat_count port.
//
// Parameters: STAGES legal range 1..8, ACC_WIDTH >= DATA_WIDTH+1.

module adder_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int STAGES     = 2,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   A,
    input  logic [LANES*DATA_WIDTH-1:0]   B,
    input  logic                          mode,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_WIDTH-1:0]    X,
    output logic [LANES-1:0]              sat
`ifdef ADDER_PIPE_COUNT_EN
    ,
    output logic [31:0]                   beat_count
`endif
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    // Per-lane accumulators
    logic [ACC_WIDTH-1:0] acc_q [LANES];
    logic [ACC_WIDTH-1:0] acc_d [LANES];

    // Results of the beat presented on A/B this cycle
    logic [LANES*ACC_WIDTH-1:0] beat_res;
    logic [LANES-1:0]           beat_sat;

    // Pipeline slots; slot STAGES-1 drives the outputs
    logic [STAGES-1:0]          vld_q;
    logic [LANES*ACC_WIDTH-1:0] res_q [STAGES];
    logic [LANES-1:0]           sat_q [STAGES];
    logic [STAGES-1:0]          load;

    logic accept;

    // A slot loads unless it and every slot after it are full while the
    // output is stalled. Computed as a suffix-AND so there is no feedback
    // through the load vector itself.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        load      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & vld_q[k];
            load[k]   = !full_tail || out_ready;
        end
    end

    assign in_ready = load[0] && !rst;
    assign accept   = in_valid && in_ready;

    // Lane arithmetic. A clear on the same cycle as an accumulate beat wins
    // first, so the beat starts from zero.
    always_comb begin
        logic [ACC_WIDTH-1:0] lane_s;
        logic [ACC_WIDTH-1:0] lane_base;
        logic [ACC_WIDTH:0]   lane_t;
        lane_s    = '0;
        lane_base = '0;
        lane_t    = '0;
        beat_res  = '0;
        beat_sat  = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l]  = acc_q[l];
            lane_s    = ACC_WIDTH'(A[l*DATA_WIDTH +: DATA_WIDTH])
                      + ACC_WIDTH'(B[l*DATA_WIDTH +: DATA_WIDTH]);
            lane_base = clear ? '0 : acc_q[l];
            lane_t    = {1'b0, lane_base} + {1'b0, lane_s};
            if (mode) begin
                if (lane_t[ACC_WIDTH]) begin
                    beat_res[l*ACC_WIDTH +: ACC_WIDTH] = ACC_MAX;
                    beat_sat[l]                        = 1'b1;
                end else begin
                    beat_res[l*ACC_WIDTH +: ACC_WIDTH] = lane_t[ACC_WIDTH-1:0];
                end
            end else begin
                beat_res[l*ACC_WIDTH +: ACC_WIDTH] = lane_s;
            end
            if (accept && mode) begin
                acc_d[l] = beat_res[l*ACC_WIDTH +: ACC_WIDTH];
            end else if (clear) begin
                acc_d[l] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                sat_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld_q[0] <= accept;
                res_q[0] <= beat_res;
                sat_q[0] <= beat_sat;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    res_q[k] <= res_q[k-1];
                    sat_q[k] <= sat_q[k-1];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign X         = res_q[STAGES-1];
    assign sat       = sat_q[STAGES-1];

`ifdef ADDER_PIPE_COUNT_EN
    logic [31:0] beat_cnt_q;

    // Wraps naturally from all-ones to zero; clear does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
        end
    end

    assign beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;

  localparam int DW  = 8;
  localparam int LN  = 4;
  localparam int ST  = 2;
  localparam int AW  = 16;
  localparam int W   = LN * AW + LN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LN*DW-1:0]  a_in = '0;
  logic [LN*DW-1:0]  b_in = '0;
  logic              mode = 1'b0;
  logic              clear = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LN*AW-1:0]  x_out;
  logic [LN-1:0]     sat_out;
`ifdef ADDER_PIPE_COUNT_EN
  logic [31:0]       beat_count;
`endif

  adder_pipe #(.DATA_WIDTH(DW), .LANES(LN), .STAGES(ST), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .mode(mode), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .X(x_out), .sat(sat_out)
`ifdef ADDER_PIPE_COUNT_EN
    , .beat_count(beat_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_hist[$];
  logic [AW:0]   acc_m[LN];
  int            n_tests = 0;
  int            n_fail = 0;
  int unsigned   hs_total = 0;
  bit            rand_done = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic for one accepted beat
  task automatic model_accept(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b,
                              input logic m, input logic c);
    logic [LN*AW-1:0] res;
    logic [LN-1:0]    s_f;
    logic [AW:0]      s, t, base;
    res = '0;
    s_f = '0;
    for (int l = 0; l < LN; l++) begin
      s = {{(AW+1-DW){1'b0}}, a[l*DW +: DW]} + {{(AW+1-DW){1'b0}}, b[l*DW +: DW]};
      if (m) begin
        base = c ? '0 : acc_m[l];
        t = base + s;
        if (t > 17'd65535) begin
          t = 17'd65535;
          s_f[l] = 1'b1;
        end
        acc_m[l] = t;
        res[l*AW +: AW] = t[AW-1:0];
      end else begin
        res[l*AW +: AW] = s[AW-1:0];
        if (c) acc_m[l] = '0;
      end
    end
    exp_q.push_back({s_f, res});
  endtask

  // Output monitor: data checked every valid cycle (held stable while stalled)
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_data", {sat_out, x_out}, exp_q[0]);
        if (out_ready) begin
          got_hist.push_back({sat_out, x_out});
          void'(exp_q.pop_front());
          hs_total++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b,
                      input logic m, input logic c);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; a_in = a; b_in = b; mode = m; clear = c;
    for (int w = 0; w < 300 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(a, b, m, c);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      // a stalled clear still empties the model accumulators
      if (!done && c) for (int l = 0; l < LN; l++) acc_m[l] = '0;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic clear_idle();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int l = 0; l < LN; l++) acc_m[l] = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LN*DW-1:0] splat(input logic [DW-1:0] v);
    return {LN{v}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int l = 0; l < LN; l++) acc_m[l] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_x", x_out, 0);
    check("rst_sat", sat_out, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 1: plain add and latency
    got_hist.delete();
    send({8'h80, 8'h00, 8'h00, 8'hFF}, {8'h80, 8'h00, 8'h00, 8'h01}, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_lat_early", out_valid, 0);
    @(negedge clk);
    check("t1_lat_valid", out_valid, 1);
    drain();
    check("t1_lane0", got_hist[0][15:0], 16'h0100);
    check("t1_lane3", got_hist[0][63:48], 16'h0100);
    check("t1_sat", got_hist[0][W-1 -: LN], 4'b0000);

    // 2: back-to-back with output stall
    got_hist.delete();
    out_ready = 1'b0;
    for (int bt = 0; bt < 2; bt++)
      send({8'(3 + bt), 8'(2 + bt), 8'(1 + bt), 8'(bt)}, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_in_ready_full", in_ready, 0);
    @(posedge clk);
    #1;
    fork
      begin
        for (int bt = 2; bt < 6; bt++)
          send({8'(3 + bt), 8'(2 + bt), 8'(1 + bt), 8'(bt)}, '0, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("t2_count", got_hist.size(), 6);
    check("t2_beat5_lane3", got_hist[5][63:48], 16'd8);

    // 3: saturating accumulate
    got_hist.delete();
    for (int bt = 0; bt < 130; bt++) send(splat(8'hFF), splat(8'hFF), 1'b1, bt == 0);
    drain();
    check("t3_b128_x", got_hist[127][LN*AW-1:0], {4{16'hFF00}});
    check("t3_b128_sat", got_hist[127][W-1 -: LN], 4'b0000);
    check("t3_b129_x", got_hist[128][LN*AW-1:0], {4{16'hFFFF}});
    check("t3_b129_sat", got_hist[128][W-1 -: LN], 4'b1111);
    check("t3_b130_x", got_hist[129][LN*AW-1:0], {4{16'hFFFF}});
    check("t3_b130_sat", got_hist[129][W-1 -: LN], 4'b1111);

    // 4: clear coincident with accumulate
    clear_idle();
    got_hist.delete();
    for (int bt = 0; bt < 5; bt++) send(splat(8'd200), '0, 1'b1, 1'b0);
    send(splat(8'd3), splat(8'd4), 1'b1, 1'b1);
    send(splat(8'd1), '0, 1'b1, 1'b0);
    drain();
    check("t4_acc1000", got_hist[4][15:0], 16'h03E8);
    check("t4_clear_res", got_hist[5][15:0], 16'd7);
    check("t4_next_res", got_hist[6][15:0], 16'd8);

    // random mixed traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int bt = 0; bt < 40; bt++)
          send($urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand_idle", out_valid, 0);

    // 5: asynchronous reset mid-flight
    out_ready = 1'b0;
    send(splat(8'd9), '0, 1'b1, 1'b0);
    send(splat(8'd9), '0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_x", x_out, 0);
    exp_q.delete();
    for (int l = 0; l < LN; l++) acc_m[l] = '0;
    hs_total = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_in_ready_rel", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    got_hist.delete();
    send(splat(8'd5), '0, 1'b1, 1'b0);
    drain();
    check("t5_first_acc", got_hist[0][LN*AW-1:0], {4{16'd5}});

`ifdef ADDER_PIPE_COUNT_EN
    // 6: beat counter
    rand_done = 1'b0;
    fork
      begin
        for (int bt = 0; bt < 10; bt++) send($urandom(), $urandom(), 1'b0, 1'b0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("t6_count", beat_count, 32'(hs_total));
    check("t6_count11", beat_count, 32'd11);
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.beat_cnt_q;
    send(splat(8'd1), '0, 1'b0, 1'b0);
    drain();
    check("t6_wrap", beat_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
